// File: rtl/btn_cmd_ctrl.sv
// Registered button-command stage: inc/dec/clear/complement on a WIDTH-bit LED count,
// with hold-to-repeat on inc/dec. Define BTN_CMD_SATURATE_EN to saturate instead of wrap.
module btn_cmd_ctrl #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       tick,
    input  logic [3:0]       level,
    output logic [WIDTH-1:0] leds,
    output logic             step,
    output logic             repeating
);

    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HOLD,
        REPEAT
    } state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             dir, dir_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             step_nxt;
    logic             do_op;
    logic             op_dir;
    logic             apply;
    logic             held;
    logic             excl;
    logic [TW-1:0]    last;

    // clear/complement buttons have no hold behaviour, so their levels are not used
    logic unused_level;
    assign unused_level = ^level[3:2];

    assign excl = tick[0] ^ tick[1];
    assign held = dir ? level[1] : level[0];
    assign last = (state == REPEAT) ? REPEAT_LAST : HOLD_LAST;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        dir_nxt   = dir;
        count_nxt = leds;
        step_nxt  = 1'b0;
        do_op     = 1'b0;
        op_dir    = dir;
        apply     = 1'b0;

        if (tick[2]) begin
            count_nxt = '0;
            state_nxt = IDLE;
            timer_nxt = '0;
        end else if (tick[3]) begin
            count_nxt = ~leds;
            state_nxt = IDLE;
            timer_nxt = '0;
        end else if (excl && (state == IDLE || tick[1] != dir)) begin
            do_op     = 1'b1;
            op_dir    = tick[1];
            dir_nxt   = tick[1];
            timer_nxt = '0;
            state_nxt = WAIT_HOLD;
        end else if (!(tick[0] && tick[1]) && state != IDLE) begin
            // same-direction ticks fall through here and are treated as plain holding
            if (!held) begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end else if (timer == last) begin
                do_op     = 1'b1;
                timer_nxt = '0;
                state_nxt = REPEAT;
            end else begin
                timer_nxt = timer + 1'b1;
            end
        end

`ifdef BTN_CMD_SATURATE_EN
        apply = do_op && !(op_dir ? (leds == '0) : (leds == '1));
`else
        apply = do_op;
`endif
        if (apply) begin
            count_nxt = op_dir ? (leds - 1'b1) : (leds + 1'b1);
            step_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            dir       <= 1'b0;
            leds      <= '0;
            step      <= 1'b0;
            repeating <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            dir       <= dir_nxt;
            leds      <= count_nxt;
            step      <= step_nxt;
            repeating <= (state_nxt == REPEAT);
        end
    end

endmodule
